// File: rtl/synthesijer_fcomp32_core_pkg.sv
// Shared constants and types for the binary32 compare engine:
// op codes, condition-code bit layout, field positions and result decode.
package synthesijer_fcomp32_core_pkg;

   localparam int unsigned SIGN_BIT = 31;
   localparam int unsigned EXP_MSB  = 30;
   localparam int unsigned EXP_LSB  = 23;
   localparam int unsigned MANT_MSB = 22;

   localparam int unsigned OP_MSB = 5;
   localparam int unsigned OP_LSB = 3;

   localparam int unsigned CC_UNORD = 3;
   localparam int unsigned CC_GT    = 2;
   localparam int unsigned CC_LT    = 1;
   localparam int unsigned CC_EQ    = 0;

   typedef enum logic [2:0] {
      FCMP_UNORD = 3'd0,
      FCMP_LT    = 3'd1,
      FCMP_EQ    = 3'd2,
      FCMP_LE    = 3'd3,
      FCMP_GT    = 3'd4,
      FCMP_NE    = 3'd5,
      FCMP_GE    = 3'd6,
      FCMP_CC    = 3'd7
   } fcmp_op_e;

   // Field order matches the condition-code bit indices above.
   typedef struct packed {
      logic unord;
      logic gt;
      logic lt;
      logic eq;
   } rel_t;

   typedef struct packed {
      logic     valid;
      rel_t     cc;
      fcmp_op_e op;
   } stage_t;

   function automatic logic [7:0] fcmp_decode(input fcmp_op_e op, input rel_t cc);
      logic [7:0] r;
      r = '0;
      case (op)
         FCMP_UNORD: r[0] = cc.unord;
         FCMP_LT:    r[0] = cc.lt;
         FCMP_EQ:    r[0] = cc.eq;
         FCMP_LE:    r[0] = cc.lt | cc.eq;
         FCMP_GT:    r[0] = cc.gt;
         FCMP_NE:    r[0] = ~cc.eq;
         FCMP_GE:    r[0] = cc.gt | cc.eq;
         FCMP_CC:    r[CC_UNORD:CC_EQ] = cc;
         default:    r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/synthesijer_fcomp32_core_if.sv
// AXI4-Stream channel bundle of the compare engine: three operand/op inputs
// joined into one result stream.
interface synthesijer_fcomp32_core_if;
   logic [31:0] s_axis_a_tdata;
   logic        s_axis_a_tvalid;
   logic        s_axis_a_tready;
   logic [31:0] s_axis_b_tdata;
   logic        s_axis_b_tvalid;
   logic        s_axis_b_tready;
   logic [7:0]  s_axis_operation_tdata;
   logic        s_axis_operation_tvalid;
   logic        s_axis_operation_tready;
   logic [7:0]  m_axis_result_tdata;
   logic        m_axis_result_tvalid;
   logic        m_axis_result_tready;

   modport slave (
      input  s_axis_a_tdata, s_axis_a_tvalid,
      output s_axis_a_tready,
      input  s_axis_b_tdata, s_axis_b_tvalid,
      output s_axis_b_tready,
      input  s_axis_operation_tdata, s_axis_operation_tvalid,
      output s_axis_operation_tready,
      output m_axis_result_tdata, m_axis_result_tvalid,
      input  m_axis_result_tready
   );

   modport master (
      output s_axis_a_tdata, s_axis_a_tvalid,
      input  s_axis_a_tready,
      output s_axis_b_tdata, s_axis_b_tvalid,
      input  s_axis_b_tready,
      output s_axis_operation_tdata, s_axis_operation_tvalid,
      input  s_axis_operation_tready,
      input  m_axis_result_tdata, m_axis_result_tvalid,
      output m_axis_result_tready
   );
endinterface

// File: rtl/synthesijer_fcomp32_rel.sv
// Combinational binary32 relation: unordered / equal / less / greater,
// with optional flushing of subnormals to signed zero.
module synthesijer_fcomp32_rel
   import synthesijer_fcomp32_core_pkg::*;
#(
   parameter bit DENORM_FLUSH = 1'b1
) (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        unord,
   output logic        eq,
   output logic        lt,
   output logic        gt
);

   logic        a_nan, b_nan, a_zero, b_zero, a_less;
   logic [30:0] a_mag, b_mag;

   always_comb begin
      a_nan  = (a[EXP_MSB:EXP_LSB] == '1) && (a[MANT_MSB:0] != '0);
      b_nan  = (b[EXP_MSB:EXP_LSB] == '1) && (b[MANT_MSB:0] != '0);
      a_zero = (a[EXP_MSB:EXP_LSB] == '0) && ((a[MANT_MSB:0] == '0) || DENORM_FLUSH);
      b_zero = (b[EXP_MSB:EXP_LSB] == '0) && ((b[MANT_MSB:0] == '0) || DENORM_FLUSH);
      a_mag  = a_zero ? '0 : a[EXP_MSB:0];
      b_mag  = b_zero ? '0 : b[EXP_MSB:0];
      a_less = a_mag < b_mag;

      unord = a_nan | b_nan;
      eq    = 1'b0;
      lt    = 1'b0;
      gt    = 1'b0;
      if (!unord) begin
         if (a_zero && b_zero) begin
            eq = 1'b1;
         end else if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            lt = a[SIGN_BIT];
            gt = b[SIGN_BIT];
         end else if (a_mag == b_mag) begin
            eq = 1'b1;
         end else begin
            // Same sign: negative operands invert the magnitude order.
            lt = a_less ^ a[SIGN_BIT];
            gt = ~(a_less ^ a[SIGN_BIT]);
         end
      end
   end

endmodule

// File: rtl/synthesijer_fcomp32_core.sv
// Single-precision compare engine: joins A/B/op beats, compares through a
// LATENCY-deep global-stall pipeline and returns one result byte per beat.
module synthesijer_fcomp32_core
   import synthesijer_fcomp32_core_pkg::*;
#(
   parameter int unsigned LATENCY      = 2,
   parameter bit          DENORM_FLUSH = 1'b1
) (
   input logic                          clk,
   input logic                          reset,
   synthesijer_fcomp32_core_if.slave    bus
);

   logic        adv, fire;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [31:0] rel_a, rel_b;
   logic        head_valid;
   fcmp_op_e    head_op;
   logic        rel_unord, rel_eq, rel_lt, rel_gt;
   stage_t      head, tail;

   assign adv  = !out_valid || bus.m_axis_result_tready;
   assign fire = reset && adv && bus.s_axis_a_tvalid && bus.s_axis_b_tvalid
                 && bus.s_axis_operation_tvalid;

   assign bus.s_axis_a_tready         = fire;
   assign bus.s_axis_b_tready         = fire;
   assign bus.s_axis_operation_tready = fire;
   assign bus.m_axis_result_tvalid    = out_valid;
   assign bus.m_axis_result_tdata     = out_data;

   // With a single stage the relation is evaluated straight off the inputs.
   if (LATENCY == 1) begin : g_direct
      assign rel_a      = bus.s_axis_a_tdata;
      assign rel_b      = bus.s_axis_b_tdata;
      assign head_valid = fire;
      assign head_op    = fcmp_op_e'(bus.s_axis_operation_tdata[OP_MSB:OP_LSB]);
   end else begin : g_s0
      logic        s0_valid;
      logic [31:0] s0_a, s0_b;
      fcmp_op_e    s0_op;

      always_ff @(posedge clk) begin
         if (!reset) begin
            s0_valid <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_op    <= FCMP_UNORD;
         end else if (adv) begin
            s0_valid <= fire;
            if (fire) begin
               s0_a  <= bus.s_axis_a_tdata;
               s0_b  <= bus.s_axis_b_tdata;
               s0_op <= fcmp_op_e'(bus.s_axis_operation_tdata[OP_MSB:OP_LSB]);
            end
         end
      end

      assign rel_a      = s0_a;
      assign rel_b      = s0_b;
      assign head_valid = s0_valid;
      assign head_op    = s0_op;
   end

   synthesijer_fcomp32_rel #(.DENORM_FLUSH(DENORM_FLUSH)) u_rel (
      .a     (rel_a),
      .b     (rel_b),
      .unord (rel_unord),
      .eq    (rel_eq),
      .lt    (rel_lt),
      .gt    (rel_gt)
   );

   assign head = '{valid: head_valid,
                   cc:    '{unord: rel_unord, gt: rel_gt, lt: rel_lt, eq: rel_eq},
                   op:    head_op};

   if (LATENCY > 2) begin : g_mid
      stage_t mid_q [LATENCY-2];

      always_ff @(posedge clk) begin
         if (!reset) begin
            for (int unsigned i = 0; i < LATENCY - 2; i++) mid_q[i] <= '0;
         end else if (adv) begin
            mid_q[0] <= head;
            for (int unsigned i = 1; i < LATENCY - 2; i++) mid_q[i] <= mid_q[i-1];
         end
      end

      assign tail = mid_q[LATENCY-3];
   end else begin : g_nomid
      assign tail = head;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (adv) begin
         out_valid <= tail.valid;
         if (tail.valid) out_data <= fcmp_decode(tail.op, tail.cc);
      end
   end

endmodule

// File: tb/tb_synthesijer_fcomp32_core.sv
// Self-checking bench for synthesijer_fcomp32_core: directed vector table,
// stall / stagger / reset sequences and a randomized stream vs a real-valued model.
module tb_synthesijer_fcomp32_core;

   localparam int unsigned LAT   = 2;
   localparam bit          FLUSH = 1'b1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   synthesijer_fcomp32_core_if bus();

   synthesijer_fcomp32_core #(.LATENCY(LAT), .DENORM_FLUSH(FLUSH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: operands become real numbers, relation by real compare.
   function automatic bit is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   function automatic real to_real(input logic [31:0] x);
      int  e;
      real frac, mag;
      e    = int'({24'd0, x[30:23]});
      frac = real'(int'({9'd0, x[22:0]})) / 8388608.0;
      if (e == 255)     mag = 1.0e300;
      else if (e == 0)  mag = FLUSH ? 0.0 : frac * (2.0 ** (-126));
      else              mag = (1.0 + frac) * (2.0 ** (e - 127));
      return x[31] ? -mag : mag;
   endfunction

   function automatic logic [7:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [7:0] op);
      bit un, eq, lt, gt;
      real ra, rb;
      logic [2:0] code;
      un   = is_nan(a) || is_nan(b);
      ra   = to_real(a);
      rb   = to_real(b);
      eq   = !un && (ra == rb);
      lt   = !un && (ra < rb);
      gt   = !un && (ra > rb);
      code = op[5:3];
      case (code)
         3'd0: return {7'd0, un};
         3'd1: return {7'd0, lt};
         3'd2: return {7'd0, eq};
         3'd3: return {7'd0, lt | eq};
         3'd4: return {7'd0, gt};
         3'd5: return {7'd0, !eq};
         3'd6: return {7'd0, gt | eq};
         default: return {4'd0, un, gt, lt, eq};
      endcase
   endfunction

   // Scoreboard monitor, sampled on the falling edge.
   logic [7:0] exp_q[$];
   bit         stall_seen = 1'b0;
   logic [7:0] stall_data;
   int unsigned stall_cycles = 0;

   always @(negedge clk) begin
      bit exp_fire;
      if (!reset) begin
         exp_q.delete();
         stall_seen = 1'b0;
         check("tready_in_reset", {29'd0, bus.s_axis_a_tready, bus.s_axis_b_tready,
               bus.s_axis_operation_tready}, 32'd0);
      end else begin
         exp_fire = bus.s_axis_a_tvalid && bus.s_axis_b_tvalid && bus.s_axis_operation_tvalid
                    && (!bus.m_axis_result_tvalid || bus.m_axis_result_tready);
         check("tready_join", {29'd0, bus.s_axis_a_tready, bus.s_axis_b_tready,
               bus.s_axis_operation_tready}, exp_fire ? 32'd7 : 32'd0);
         if (exp_fire)
            exp_q.push_back(ref_cmp(bus.s_axis_a_tdata, bus.s_axis_b_tdata,
                                    bus.s_axis_operation_tdata));
         if (stall_seen) begin
            check("hold_tvalid", {31'd0, bus.m_axis_result_tvalid}, 32'd1);
            check("hold_tdata", {24'd0, bus.m_axis_result_tdata}, {24'd0, stall_data});
         end
         if (bus.m_axis_result_tvalid && bus.m_axis_result_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", {31'd0, bus.m_axis_result_tvalid}, 32'd0);
            end else begin
               check("result", {24'd0, bus.m_axis_result_tdata}, {24'd0, exp_q.pop_front()});
            end
         end
         stall_seen = bus.m_axis_result_tvalid && !bus.m_axis_result_tready;
         stall_data = bus.m_axis_result_tdata;
         if (stall_seen) stall_cycles++;
      end
   end

   task automatic set_valids(input bit a, input bit b, input bit op);
      bus.s_axis_a_tvalid         = a;
      bus.s_axis_b_tvalid         = b;
      bus.s_axis_operation_tvalid = op;
   endtask

   task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                           output logic [7:0] got, output int unsigned lat);
      @(posedge clk); #1;
      bus.s_axis_a_tdata         = a;
      bus.s_axis_b_tdata         = b;
      bus.s_axis_operation_tdata = op;
      bus.m_axis_result_tready   = 1'b1;
      set_valids(1, 1, 1);
      @(negedge clk);
      check("single_fire", {31'd0, bus.s_axis_a_tready}, 32'd1);
      got = 'x;
      lat = 0;
      for (int unsigned i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         set_valids(0, 0, 0);
         @(negedge clk);
         lat++;
         if (bus.m_axis_result_tvalid) begin
            got = bus.m_axis_result_tdata;
            break;
         end
      end
   endtask

   function automatic logic [31:0] rand_val();
      logic [31:0] specials [8];
      specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                   32'h3F800000, 32'hBF800000, 32'h7FC00000, 32'h00000001};
      case ($urandom_range(0, 5))
         0:       return specials[$urandom_range(0, 7)];
         1:       return {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom)};
         2:       return {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 8388607))};
         default: return $urandom;
      endcase
   endfunction

   // Streams beats; rand_mode randomizes valid arrival and downstream ready,
   // otherwise a fixed 3-cycle downstream stall is inserted mid-stream.
   task automatic run_stream(input int unsigned nbeats, input bit rand_mode);
      int unsigned sent = 0;
      int unsigned cyc  = 0;
      bit          presented = 0;
      logic [2:0]  on = '0;
      logic [31:0] a;
      while ((sent < nbeats || exp_q.size() != 0) && cyc < 4000) begin
         @(posedge clk); #1;
         if (!presented && sent < nbeats) begin
            a = rand_val();
            bus.s_axis_a_tdata = a;
            case ($urandom_range(0, 7))
               0, 1:    bus.s_axis_b_tdata = a;
               2:       bus.s_axis_b_tdata = a ^ 32'h80000000;
               default: bus.s_axis_b_tdata = rand_val();
            endcase
            bus.s_axis_operation_tdata = 8'($urandom);
            on        = rand_mode ? 3'($urandom) : 3'b111;
            presented = 1;
         end else if (presented) begin
            on = on | (rand_mode ? 3'($urandom) : 3'b111);
         end
         set_valids(presented && on[2], presented && on[1], presented && on[0]);
         bus.m_axis_result_tready = rand_mode ? ($urandom_range(0, 3) != 0)
                                              : !(cyc >= 5 && cyc < 8);
         @(negedge clk);
         if (bus.s_axis_a_tready) begin
            sent++;
            presented = 0;
            on        = '0;
         end
         cyc++;
      end
      set_valids(0, 0, 0);
      bus.m_axis_result_tready = 1'b1;
      check("stream_sent", sent, nbeats);
      check("stream_drained", exp_q.size(), 32'd0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  op;
      logic [7:0]  exp;
   } vec_t;

   initial begin
      vec_t        vecs [19];
      logic [7:0]  got;
      int unsigned lat;
      int unsigned seen;

      vecs = '{
         '{32'h3F800000, 32'h40000000, 8'h08, 8'h01},
         '{32'h80000000, 32'h00000000, 8'h10, 8'h01},
         '{32'h80000000, 32'h00000000, 8'h38, 8'h01},
         '{32'h7FC00000, 32'h3F800000, 8'h00, 8'h01},
         '{32'h7FC00000, 32'h3F800000, 8'h08, 8'h00},
         '{32'h7FC00000, 32'h3F800000, 8'h10, 8'h00},
         '{32'h7FC00000, 32'h3F800000, 8'h18, 8'h00},
         '{32'h7FC00000, 32'h3F800000, 8'h20, 8'h00},
         '{32'h7FC00000, 32'h3F800000, 8'h28, 8'h01},
         '{32'h7FC00000, 32'h3F800000, 8'h30, 8'h00},
         '{32'h7FC00000, 32'h3F800000, 8'h38, 8'h08},
         '{32'hC0000000, 32'hBF800000, 8'h38, 8'h02},
         '{32'hFF800000, 32'h7F800000, 8'h20, 8'h00},
         '{32'h00000001, 32'h80000000, 8'h10, 8'h01},
         '{32'h7F800000, 32'h7F800000, 8'h10, 8'h01},
         '{32'h3F800000, 32'h3F800000, 8'hDF, 8'h01},
         '{32'h40000000, 32'h3F800000, 8'h30, 8'h01},
         '{32'h3F800000, 32'hBF800000, 8'h38, 8'h04},
         '{32'hFF800000, 32'hC0000000, 8'h38, 8'h02}
      };

      bus.s_axis_a_tdata         = '0;
      bus.s_axis_b_tdata         = '0;
      bus.s_axis_operation_tdata = '0;
      set_valids(0, 0, 0);
      bus.m_axis_result_tready   = 1'b1;

      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tvalid", {31'd0, bus.m_axis_result_tvalid}, 32'd0);
      check("reset_tdata", {24'd0, bus.m_axis_result_tdata}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      foreach (vecs[i]) begin
         send_one(vecs[i].a, vecs[i].b, vecs[i].op, got, lat);
         check($sformatf("vec%0d", i), {24'd0, got}, {24'd0, vecs[i].exp});
         check($sformatf("vec%0d_latency", i), lat, LAT);
      end

      run_stream(8, 1'b0);
      check("stall_observed", {31'd0, stall_cycles >= 3}, 32'd1);

      // Staggered arrival: A, then B two cycles later, op two cycles after that.
      @(posedge clk); #1;
      bus.s_axis_a_tdata         = 32'hC0000000;
      bus.s_axis_b_tdata         = 32'h3F800000;
      bus.s_axis_operation_tdata = 8'h38;
      for (int unsigned t = 0; t < 5; t++) begin
         if (t > 0) begin
            @(posedge clk); #1;
         end
         set_valids(1, t >= 2, t >= 4);
         @(negedge clk);
         check($sformatf("stagger_t%0d", t), {31'd0, bus.s_axis_a_tready},
               (t == 4) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      set_valids(0, 0, 0);
      repeat (LAT + 2) @(posedge clk);

      // Reset with a beat in flight: nothing may emerge afterwards.
      @(posedge clk); #1;
      bus.s_axis_a_tdata         = 32'h3F800000;
      bus.s_axis_b_tdata         = 32'h40000000;
      bus.s_axis_operation_tdata = 8'h08;
      set_valids(1, 1, 1);
      @(negedge clk);
      check("inflight_fire", {31'd0, bus.s_axis_a_tready}, 32'd1);
      @(posedge clk); #1;
      set_valids(0, 0, 0);
      reset = 1'b0;
      @(negedge clk);
      check("reset_flush_tvalid", {31'd0, bus.m_axis_result_tvalid}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.m_axis_result_tvalid) seen++;
      end
      check("reset_nothing_emitted", seen, 32'd0);
      send_one(32'hBF800000, 32'h3F800000, 8'h38, got, lat);
      check("after_reset", {24'd0, got}, 32'h02);
      check("after_reset_latency", lat, LAT);

      run_stream(300, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
